// File: rtl/syx_bank_reader_if.sv
// syx_bank_reader_if: bank read bus plus the outgoing SysEx byte stream.
// master = the dump sequencer, slave = the parameter banks and transmitter.
interface syx_bank_reader_if #(
  parameter int ADR_W = 7
);
  logic [2:0]       bank_adr;
  logic [ADR_W-1:0] adr;
  logic             read;
  logic             env_sel;
  logic             osc_sel;
  logic             m1_sel;
  logic             m2_sel;
  logic             com_sel;
  logic [7:0]       rd_data;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;

  modport master (
    output bank_adr, adr, read, env_sel, osc_sel, m1_sel, m2_sel, com_sel,
    output tx_data, tx_valid,
    input  rd_data, tx_ready
  );

  modport slave (
    input  bank_adr, adr, read, env_sel, osc_sel, m1_sel, m2_sel, com_sel,
    input  tx_data, tx_valid,
    output rd_data, tx_ready
  );
endinterface

// File: rtl/syx_bank_reader.sv
// syx_bank_reader: walks every parameter bank address by address, issues
// one-cycle read strobes with one-hot bank selects, captures each returned
// byte and streams it out over a valid/ready byte interface.
// Optional feature macro: SYX_FRAME_EN wraps each bank as
// F0, bank number, 7-bit data bytes, checksum, F7.
module syx_bank_reader #(
  parameter int NUM_BANKS  = 5,
  parameter int BANK_DEPTH = 128,
  parameter int ADR_W      = 7,
  parameter int READ_LAT   = 2
) (
  input  logic              CLOCK_25,
  input  logic              iRST_N,
  input  logic              dump_start,
  input  logic              dump_abort,
  output logic              busy,
  output logic              done,
  syx_bank_reader_if.master bus
);

`ifdef SYX_FRAME_EN
  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_RD = 4'd1, S_WAIT = 4'd2, S_CAP = 4'd3, S_SEND = 4'd4,
    S_HDR = 4'd5, S_CSUM = 4'd6, S_EOX = 4'd7, S_DONE = 4'd8
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_RD = 3'd1, S_WAIT = 3'd2, S_CAP = 3'd3, S_SEND = 3'd4,
    S_DONE = 3'd5
  } state_t;
`endif

  localparam logic [ADR_W-1:0] LAST_ADR  = ADR_W'(BANK_DEPTH - 1);
  localparam logic [2:0]       LAST_BANK = 3'(NUM_BANKS - 1);
  // WAIT counts down to zero, so loading READ_LAT-2 gives READ_LAT-1 cycles.
  localparam logic [2:0]       WAIT_LOAD = 3'(READ_LAT - 2);

  // One-hot bank select; out-of-range bank numbers select nothing.
  function automatic logic [4:0] sel_decode(input logic [2:0] bank);
    logic [4:0] sel;
    case (bank)
      3'd0:    sel = 5'b00001;
      3'd1:    sel = 5'b00010;
      3'd2:    sel = 5'b00100;
      3'd3:    sel = 5'b01000;
      3'd4:    sel = 5'b10000;
      default: sel = 5'b00000;
    endcase
    return sel;
  endfunction

`ifdef SYX_FRAME_EN
  // Checksum byte: two's complement of the 7-bit data sum, bit 7 clear.
  function automatic logic [7:0] csum_byte(input logic [6:0] sum);
    return {1'b0, 7'd0 - sum};
  endfunction
`endif

  state_t           state_r, state_nxt_s;
  logic [2:0]       bank_r, bank_nxt_s;
  logic [ADR_W-1:0] adr_r, adr_nxt_s;
  logic [2:0]       wait_r, wait_nxt_s;
  logic             read_r, read_nxt_s;
  logic [4:0]       sel_r, sel_nxt_s;
  logic [7:0]       tx_data_r, tx_data_nxt_s;
  logic             tx_valid_r, tx_valid_nxt_s;
  logic             busy_r, busy_nxt_s;
  logic             done_r, done_nxt_s;
  logic             hs_s;
`ifdef SYX_FRAME_EN
  logic [6:0]       csum_r, csum_nxt_s;
  logic             phase_r, phase_nxt_s;
`endif

  assign hs_s = tx_valid_r & bus.tx_ready;

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_nxt_s    = state_r;
    bank_nxt_s     = bank_r;
    adr_nxt_s      = adr_r;
    wait_nxt_s     = wait_r;
    read_nxt_s     = 1'b0;
    tx_data_nxt_s  = tx_data_r;
    tx_valid_nxt_s = tx_valid_r;
    busy_nxt_s     = busy_r;
    done_nxt_s     = 1'b0;
`ifdef SYX_FRAME_EN
    csum_nxt_s     = csum_r;
    phase_nxt_s    = phase_r;
`endif
    if ((state_r != S_IDLE) && dump_abort) begin
      // Abort drops the in-flight byte and returns quietly, no done pulse.
      state_nxt_s    = S_IDLE;
      bank_nxt_s     = 3'd0;
      adr_nxt_s      = {ADR_W{1'b0}};
      tx_valid_nxt_s = 1'b0;
      busy_nxt_s     = 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (dump_start && !dump_abort) begin
            bank_nxt_s = 3'd0;
            adr_nxt_s  = {ADR_W{1'b0}};
            busy_nxt_s = 1'b1;
`ifdef SYX_FRAME_EN
            tx_data_nxt_s  = 8'hF0;
            tx_valid_nxt_s = 1'b1;
            phase_nxt_s    = 1'b0;
            csum_nxt_s     = 7'd0;
            state_nxt_s    = S_HDR;
`else
            read_nxt_s  = 1'b1;
            state_nxt_s = S_RD;
`endif
          end else begin
            state_nxt_s = S_IDLE;
          end
        end
        S_RD: begin
          if (READ_LAT == 1) begin
            state_nxt_s = S_CAP;
          end else begin
            wait_nxt_s  = WAIT_LOAD;
            state_nxt_s = S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_r == 3'd0) begin
            state_nxt_s = S_CAP;
          end else begin
            wait_nxt_s = wait_r - 3'd1;
          end
        end
        S_CAP: begin
`ifdef SYX_FRAME_EN
          tx_data_nxt_s = bus.rd_data & 8'h7F;
          csum_nxt_s    = csum_r + bus.rd_data[6:0];
`else
          tx_data_nxt_s = bus.rd_data;
`endif
          tx_valid_nxt_s = 1'b1;
          state_nxt_s    = S_SEND;
        end
        S_SEND: begin
          if (hs_s) begin
            tx_valid_nxt_s = 1'b0;
            if (adr_r == LAST_ADR) begin
              adr_nxt_s = {ADR_W{1'b0}};
`ifdef SYX_FRAME_EN
              tx_data_nxt_s  = csum_byte(csum_r);
              tx_valid_nxt_s = 1'b1;
              state_nxt_s    = S_CSUM;
`else
              if (bank_r == LAST_BANK) begin
                bank_nxt_s  = 3'd0;
                busy_nxt_s  = 1'b0;
                done_nxt_s  = 1'b1;
                state_nxt_s = S_DONE;
              end else begin
                bank_nxt_s  = bank_r + 3'd1;
                read_nxt_s  = 1'b1;
                state_nxt_s = S_RD;
              end
`endif
            end else begin
              adr_nxt_s   = adr_r + ADR_W'(1);
              read_nxt_s  = 1'b1;
              state_nxt_s = S_RD;
            end
          end else begin
            state_nxt_s = S_SEND;
          end
        end
`ifdef SYX_FRAME_EN
        S_HDR: begin
          if (hs_s) begin
            if (!phase_r) begin
              tx_data_nxt_s = {5'd0, bank_r};
              phase_nxt_s   = 1'b1;
            end else begin
              tx_valid_nxt_s = 1'b0;
              read_nxt_s     = 1'b1;
              state_nxt_s    = S_RD;
            end
          end else begin
            state_nxt_s = S_HDR;
          end
        end
        S_CSUM: begin
          if (hs_s) begin
            tx_data_nxt_s = 8'hF7;
            state_nxt_s   = S_EOX;
          end else begin
            state_nxt_s = S_CSUM;
          end
        end
        S_EOX: begin
          if (hs_s) begin
            if (bank_r == LAST_BANK) begin
              tx_valid_nxt_s = 1'b0;
              bank_nxt_s     = 3'd0;
              busy_nxt_s     = 1'b0;
              done_nxt_s     = 1'b1;
              state_nxt_s    = S_DONE;
            end else begin
              bank_nxt_s    = bank_r + 3'd1;
              tx_data_nxt_s = 8'hF0;
              phase_nxt_s   = 1'b0;
              csum_nxt_s    = 7'd0;
              state_nxt_s   = S_HDR;
            end
          end else begin
            state_nxt_s = S_EOX;
          end
        end
`endif
        S_DONE: begin
          state_nxt_s = S_IDLE;
        end
        default: begin
          state_nxt_s    = S_IDLE;
          tx_valid_nxt_s = 1'b0;
          busy_nxt_s     = 1'b0;
        end
      endcase
    end
    // Selects follow the bank only while a dump is in progress.
    if (busy_nxt_s) begin
      sel_nxt_s = sel_decode(bank_nxt_s);
    end else begin
      sel_nxt_s = 5'b00000;
    end
  end

  // State register and registered outputs, cleared by the async reset.
  always_ff @(posedge CLOCK_25 or negedge iRST_N) begin
    if (!iRST_N) begin
      state_r    <= S_IDLE;
      bank_r     <= 3'd0;
      adr_r      <= {ADR_W{1'b0}};
      wait_r     <= 3'd0;
      read_r     <= 1'b0;
      sel_r      <= 5'b00000;
      tx_data_r  <= 8'h00;
      tx_valid_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
`ifdef SYX_FRAME_EN
      csum_r     <= 7'd0;
      phase_r    <= 1'b0;
`endif
    end else begin
      state_r    <= state_nxt_s;
      bank_r     <= bank_nxt_s;
      adr_r      <= adr_nxt_s;
      wait_r     <= wait_nxt_s;
      read_r     <= read_nxt_s;
      sel_r      <= sel_nxt_s;
      tx_data_r  <= tx_data_nxt_s;
      tx_valid_r <= tx_valid_nxt_s;
      busy_r     <= busy_nxt_s;
      done_r     <= done_nxt_s;
`ifdef SYX_FRAME_EN
      csum_r     <= csum_nxt_s;
      phase_r    <= phase_nxt_s;
`endif
    end
  end

  assign bus.bank_adr = bank_r;
  assign bus.adr      = adr_r;
  assign bus.read     = read_r;
  assign bus.env_sel  = sel_r[0];
  assign bus.osc_sel  = sel_r[1];
  assign bus.m1_sel   = sel_r[2];
  assign bus.m2_sel   = sel_r[3];
  assign bus.com_sel  = sel_r[4];
  assign bus.tx_data  = tx_data_r;
  assign bus.tx_valid = tx_valid_r;
  assign busy         = busy_r;
  assign done         = done_r;

endmodule

// File: tb/tb_syx_bank_reader.sv
// Directed bench for syx_bank_reader: BANK_DEPTH=4, NUM_BANKS=5, READ_LAT=3.
// The bank model answers {bank,adr}^mask exactly READ_LAT cycles after the
// strobe and a poison byte otherwise. Expected streams follow SYX_FRAME_EN.
`timescale 1ns/1ps
module tb_syx_bank_reader;
  localparam int NB = 5;
  localparam int BD = 4;
  localparam int AW = 7;
  localparam int RL = 3;
  localparam logic [7:0] POISON = 8'hEE;
`ifdef SYX_FRAME_EN
  localparam int FIRST_HS = 0;
  localparam int DONE_CYC = 120;
  localparam int ABORT_N  = 19;
  localparam logic FIRST_READ = 1'b0;
`else
  localparam int FIRST_HS = 4;
  localparam int DONE_CYC = 100;
  localparam int ABORT_N  = 9;
  localparam logic FIRST_READ = 1'b1;
`endif

  logic clk = 1'b0;
  logic rst_n, dump_start, dump_abort, busy, done;
  logic [7:0] mask;
  logic [4:0] sel_w;

  syx_bank_reader_if #(.ADR_W(AW)) bus ();

  syx_bank_reader #(.NUM_BANKS(NB), .BANK_DEPTH(BD), .ADR_W(AW), .READ_LAT(RL)) dut (
    .CLOCK_25(clk), .iRST_N(rst_n), .dump_start(dump_start), .dump_abort(dump_abort),
    .busy(busy), .done(done), .bus(bus)
  );

  always #20 clk = ~clk;

  assign sel_w = {bus.com_sel, bus.m2_sel, bus.m1_sel, bus.osc_sel, bus.env_sel};

  // Bank model pipeline: data valid only in the cycle RL after the strobe.
  logic       pv [RL];
  logic [2:0] pb [RL];
  logic [6:0] pa [RL];
  always @(posedge clk) begin
    pv[0] <= bus.read;
    pb[0] <= bus.bank_adr;
    pa[0] <= bus.adr;
    for (int i = 1; i < RL; i++) begin
      pv[i] <= pv[i-1];
      pb[i] <= pb[i-1];
      pa[i] <= pa[i-1];
    end
  end
  assign bus.rd_data = pv[RL-1] ? ({1'b0, pb[RL-1], pa[RL-1][3:0]} ^ mask) : POISON;

  int chk_cnt = 0;
  int pass_cnt = 0;
  logic [7:0] exp_q[$];
  int         exp_bank_q[$];
  logic [7:0] got_q[$];
  int         hs_cyc_q[$];
  logic [4:0] hs_sel_q[$];
  int done_cnt, done_cyc, stab_err, sel_err, busy_at_done;

  task automatic build_expected(input logic [7:0] m);
    logic [7:0] d;
`ifdef SYX_FRAME_EN
    logic [6:0] sum;
`endif
    exp_q.delete();
    exp_bank_q.delete();
    for (int b = 0; b < NB; b++) begin
`ifdef SYX_FRAME_EN
      sum = 7'd0;
      exp_q.push_back(8'hF0);  exp_bank_q.push_back(b);
      exp_q.push_back(8'(b));  exp_bank_q.push_back(b);
`endif
      for (int a = 0; a < BD; a++) begin
        d = {1'b0, 3'(b), 4'(a)} ^ m;
`ifdef SYX_FRAME_EN
        d = {1'b0, d[6:0]};
        sum = sum + d[6:0];
`endif
        exp_q.push_back(d);
        exp_bank_q.push_back(b);
      end
`ifdef SYX_FRAME_EN
      exp_q.push_back({1'b0, 7'd0 - sum}); exp_bank_q.push_back(b);
      exp_q.push_back(8'hF7);              exp_bank_q.push_back(b);
`endif
    end
  endtask

  task automatic pulse_start();
    dump_start = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
  endtask

  // Observes the stream one cycle per negedge until done (+4 cycles) or budget.
  task automatic collect(input bit rnd, input int budget);
    logic stall;
    logic [7:0] held;
    got_q.delete(); hs_cyc_q.delete(); hs_sel_q.delete();
    done_cnt = 0; done_cyc = -1; stab_err = 0; sel_err = 0; busy_at_done = 0;
    stall = 1'b0; held = 8'h00;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (done_cyc >= 0 && cyc > done_cyc + 4) break;
      bus.tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall && (!bus.tx_valid || bus.tx_data !== held)) stab_err++;
      if (bus.tx_valid && bus.tx_ready) begin
        got_q.push_back(bus.tx_data);
        hs_cyc_q.push_back(cyc);
        hs_sel_q.push_back(sel_w);
      end
      stall = bus.tx_valid && !bus.tx_ready;
      held  = bus.tx_data;
      if (busy ? !$onehot(sel_w) : (sel_w != 5'd0)) sel_err++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        if (busy) busy_at_done++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; dump_start = 1'b0; dump_abort = 1'b0; bus.tx_ready = 1'b0; mask = 8'h00;
    for (int i = 0; i < RL; i++) pv[i] = 1'b0;
    repeat (3) @(negedge clk);
    chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
    chk_cnt++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else pass_cnt++;
    chk_cnt++; if (bus.read !== 1'b0) $display("FAIL reset_read got=%b exp=0", bus.read); else pass_cnt++;
    chk_cnt++; if (bus.tx_valid !== 1'b0) $display("FAIL reset_tx_valid got=%b exp=0", bus.tx_valid); else pass_cnt++;
    chk_cnt++; if (bus.tx_data !== 8'h00) $display("FAIL reset_tx_data got=%h exp=00", bus.tx_data); else pass_cnt++;
    chk_cnt++; if (sel_w !== 5'd0) $display("FAIL reset_sel got=%b exp=00000", sel_w); else pass_cnt++;
    chk_cnt++; if (bus.bank_adr !== 3'd0) $display("FAIL reset_bank got=%0d exp=0", bus.bank_adr); else pass_cnt++;
    chk_cnt++; if (bus.adr !== 7'd0) $display("FAIL reset_adr got=%0d exp=0", bus.adr); else pass_cnt++;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_cnt++; if (busy !== 1'b0) $display("FAIL idle_busy got=%b exp=0", busy); else pass_cnt++;
  endtask

  task automatic test_full_dump();
    mask = 8'h00; build_expected(mask); bus.tx_ready = 1'b1;
    pulse_start();
    chk_cnt++; if (busy !== 1'b1) $display("FAIL start_busy got=%b exp=1", busy); else pass_cnt++;
    chk_cnt++; if (sel_w !== 5'b00001) $display("FAIL start_sel got=%b exp=00001", sel_w); else pass_cnt++;
    chk_cnt++; if (bus.read !== FIRST_READ) $display("FAIL start_read got=%b exp=%b", bus.read, FIRST_READ); else pass_cnt++;
    collect(1'b0, 2000);
    chk_cnt++; if (got_q.size() != exp_q.size()) $display("FAIL full_count got=%0d exp=%0d", got_q.size(), exp_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      chk_cnt++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) $display("FAIL full_byte[%0d] got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 8'h00, exp_q[i]);
      else pass_cnt++;
      chk_cnt++;
      if (i >= hs_sel_q.size() || hs_sel_q[i] !== 5'(5'b00001 << exp_bank_q[i])) $display("FAIL full_sel[%0d] got=%b exp=%b", i, (i < hs_sel_q.size()) ? hs_sel_q[i] : 5'd0, 5'(5'b00001 << exp_bank_q[i]));
      else pass_cnt++;
    end
    chk_cnt++; if (hs_cyc_q.size() == 0 || hs_cyc_q[0] != FIRST_HS) $display("FAIL first_hs_cycle got=%0d exp=%0d", (hs_cyc_q.size() > 0) ? hs_cyc_q[0] : -1, FIRST_HS); else pass_cnt++;
    chk_cnt++; if (done_cnt != 1) $display("FAIL full_done_count got=%0d exp=1", done_cnt); else pass_cnt++;
    chk_cnt++; if (done_cyc != DONE_CYC) $display("FAIL done_cycle got=%0d exp=%0d", done_cyc, DONE_CYC); else pass_cnt++;
    chk_cnt++; if (busy_at_done != 0) $display("FAIL busy_with_done got=%0d exp=0", busy_at_done); else pass_cnt++;
    chk_cnt++; if (sel_err != 0) $display("FAIL full_sel_onehot got=%0d exp=0", sel_err); else pass_cnt++;
  endtask

  task automatic test_random_ready();
    mask = 8'h80; build_expected(mask); bus.tx_ready = 1'b0;
    pulse_start();
    collect(1'b1, 4000);
    chk_cnt++; if (got_q.size() != exp_q.size()) $display("FAIL rnd_count got=%0d exp=%0d", got_q.size(), exp_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      chk_cnt++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) $display("FAIL rnd_byte[%0d] got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 8'h00, exp_q[i]);
      else pass_cnt++;
    end
    chk_cnt++; if (stab_err != 0) $display("FAIL rnd_stall_stable got=%0d exp=0", stab_err); else pass_cnt++;
    chk_cnt++; if (done_cnt != 1) $display("FAIL rnd_done_count got=%0d exp=1", done_cnt); else pass_cnt++;
    chk_cnt++; if (sel_err != 0) $display("FAIL rnd_sel_onehot got=%0d exp=0", sel_err); else pass_cnt++;
  endtask

  task automatic test_abort_restart();
    bit found;
    int dones;
    mask = 8'h00; build_expected(mask); bus.tx_ready = 1'b1;
    pulse_start();
    got_q.delete(); found = 1'b0;
    for (int cyc = 0; cyc < 400 && !found; cyc++) begin
      dump_start = (cyc == 7);
      if (bus.tx_valid && bus.tx_ready) got_q.push_back(bus.tx_data);
      if (bus.bank_adr == 3'd2 && bus.adr == 7'd1) found = 1'b1;
      else @(negedge clk);
    end
    dump_start = 1'b0;
    chk_cnt++; if (!found) $display("FAIL abort_reach_b2a1 got=0 exp=1"); else pass_cnt++;
    chk_cnt++; if (got_q.size() != ABORT_N) $display("FAIL abort_prefix_count got=%0d exp=%0d", got_q.size(), ABORT_N); else pass_cnt++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk_cnt++;
      if (got_q[i] !== exp_q[i]) $display("FAIL abort_prefix[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); else pass_cnt++;
    end
    dump_abort = 1'b1;
    @(negedge clk);
    chk_cnt++; if (busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", busy); else pass_cnt++;
    chk_cnt++; if (bus.tx_valid !== 1'b0) $display("FAIL abort_tx_valid got=%b exp=0", bus.tx_valid); else pass_cnt++;
    chk_cnt++; if (bus.read !== 1'b0) $display("FAIL abort_read got=%b exp=0", bus.read); else pass_cnt++;
    chk_cnt++; if (sel_w !== 5'd0) $display("FAIL abort_sel got=%b exp=00000", sel_w); else pass_cnt++;
    dump_abort = 1'b0;
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      if (done || busy) dones++;
      @(negedge clk);
    end
    chk_cnt++; if (dones != 0) $display("FAIL abort_quiet got=%0d exp=0", dones); else pass_cnt++;
    pulse_start();
    collect(1'b0, 2000);
    chk_cnt++; if (got_q.size() != exp_q.size()) $display("FAIL restart_count got=%0d exp=%0d", got_q.size(), exp_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      chk_cnt++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) $display("FAIL restart_byte[%0d] got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 8'h00, exp_q[i]);
      else pass_cnt++;
    end
    chk_cnt++; if (done_cnt != 1) $display("FAIL restart_done_count got=%0d exp=1", done_cnt); else pass_cnt++;
  endtask

  task automatic test_reset_mid_send();
    bit found;
    int dones;
    logic [26:0] snap;
    mask = 8'h00; bus.tx_ready = 1'b0;
    pulse_start();
    found = 1'b0;
    for (int cyc = 0; cyc < 50 && !found; cyc++) begin
      if (bus.tx_valid) found = 1'b1;
      else @(negedge clk);
    end
    chk_cnt++; if (!found) $display("FAIL rst_reach_send got=0 exp=1"); else pass_cnt++;
    #5 rst_n = 1'b0;
    #1;
    snap = {busy, done, bus.read, bus.tx_valid, sel_w, bus.tx_data, bus.bank_adr, bus.adr};
    chk_cnt++; if (snap !== 27'd0) $display("FAIL rst_mid_outputs got=%h exp=0", snap); else pass_cnt++;
    chk_cnt++; if (bus.tx_valid !== 1'b0) $display("FAIL rst_mid_tx_valid got=%b exp=0", bus.tx_valid); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    bus.tx_ready = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) dones++;
      @(negedge clk);
    end
    chk_cnt++; if (dones != 0) $display("FAIL rst_no_done got=%0d exp=0", dones); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_full_dump();
    test_random_ready();
    test_abort_restart();
    test_reset_mid_send();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
